axis_uart_rx: RTL and testbench

UART receiver with an AXI-Stream master output: the receive-side counterpart of `axis_uart_tx`. It deserialises frames from the `uart_rx` line and presents each byte on an 8-bit AXIS master port. It also reports per-byte parity and framing status and a one-cycle overrun pulse. It is driven by the same APB register fields as the transmitter (`delitel`, `stop_bit_num`, `parity_bit_mode`) so that both directions share one line configuration.

---
 rtl/axis_uart_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_axis_uart_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_rx.sv
// axis_uart_rx: UART receiver with a one-deep AXI-Stream master output.
// Frame: start(0), 8 data bits LSB first, one parity bit, 1 or 2 stop bits.
// Line configuration (delitel, stop_bit_num, parity_bit_mode) is latched at
// start detection so mid-frame register writes only affect the next frame.
// Optional build macro AXIS_UART_RX_MAJORITY_EN: each bit decision becomes a
// 2-of-3 vote over consecutive samples, moving every decision 1 cycle later.
module axis_uart_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [7:0]  maxis_data_o,
  output logic [1:0]  maxis_tuser_o,
  output logic        maxis_tvalid_o,
  input  logic        maxis_tready_i,
  output logic        overrun_o,
  input  logic [31:0] delitel,
  input  logic        stop_bit_num,
  input  logic [2:0]  parity_bit_mode
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  // Synchroniser and edge-detect history; all idle-high.
  logic        sync1_q, rx_s_q, rx_prev_q;

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;

  // Latched line configuration for the frame in flight.
  logic [31:0] p_q, p_d;
  logic        stop2_q, stop2_d;
  logic [2:0]  mode_q, mode_d;

  logic [31:0] p_eff, h_w, start_pt, bit_pt;
  logic        bit_s;
  logic        exp_par;
  logic        frame_done;
  logic [1:0]  frame_tuser;

  logic [7:0]  data_q;
  logic [1:0]  tuser_q;
  logic        tvalid_q;
  logic        overrun_q;

  // Periods shorter than 4 cycles would leave no room for a half-bit offset.
  assign p_eff  = (delitel < 32'd4) ? 32'd4 : delitel;
  assign h_w    = {1'b0, p_q[31:1]};
  assign bit_pt = p_q - 32'd1;

`ifdef AXIS_UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  // Keep the two previous synchronised samples for the 2-of-3 vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign start_pt = h_w;
  assign bit_s    = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) |
                    (hist_q[0] & rx_s_q);
`else
  assign start_pt = h_w - 32'd1;
  assign bit_s    = rx_s_q;
`endif

  // Expected parity bit for the byte just assembled, per the latched mode.
  always_comb begin
    case (mode_q)
      3'd1:    exp_par = 1'b1;
      3'd2:    exp_par = ~^shift_q;
      3'd3:    exp_par = ^shift_q;
      default: exp_par = 1'b0;
    endcase
  end

  // Two-flop synchroniser plus one more stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= uart_rx;
      rx_s_q    <= sync1_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM next-state: counter runs freely and wraps at each decision point.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 32'd1;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    p_d         = p_q;
    stop2_d     = stop2_q;
    mode_d      = mode_q;
    frame_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 32'd0;
        // Requires a genuine high-to-low transition, so a held break is ignored.
        if (rx_prev_q && !rx_s_q) begin
          state_d  = ST_START;
          p_d      = p_eff;
          stop2_d  = stop_bit_num;
          mode_d   = parity_bit_mode;
          bitcnt_d = 3'd0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_q == start_pt) begin
          cnt_d   = 32'd0;
          state_d = bit_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == bit_pt) begin
          cnt_d    = 32'd0;
          shift_d  = {bit_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_q == bit_pt) begin
          cnt_d   = 32'd0;
          perr_d  = (bit_s != exp_par);
          state_d = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (cnt_q == bit_pt) begin
          cnt_d  = 32'd0;
          ferr_d = ferr_q | ~bit_s;
          if (stop2_q) begin
            state_d = ST_STOP2;
          end else begin
            state_d    = ST_IDLE;
            frame_done = 1'b1;
          end
        end
      end
      ST_STOP2: begin
        if (cnt_q == bit_pt) begin
          cnt_d      = 32'd0;
          ferr_d     = ferr_q | ~bit_s;
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // Status for the byte completing this cycle includes the current stop sample.
  assign frame_tuser = {ferr_d, perr_q};

  // Frame FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 32'd0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'd0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      p_q      <= 32'd4;
      stop2_q  <= 1'b0;
      mode_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      p_q      <= p_d;
      stop2_q  <= stop2_d;
      mode_q   <= mode_d;
    end
  end

  // One-deep AXIS output register; a byte arriving while full is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= 8'd0;
      tuser_q   <= 2'd0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!tvalid_q || maxis_tready_i) begin
          data_q   <= shift_q;
          tuser_q  <= frame_tuser;
          tvalid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (tvalid_q && maxis_tready_i) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign maxis_data_o   = data_q;
  assign maxis_tuser_o  = tuser_q;
  assign maxis_tvalid_o = tvalid_q;
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// Directed testbench for axis_uart_rx: serial frames driven bit by bit,
// beats captured by a monitor, checks made with immediate assertions.
module tb_axis_uart_rx;

`ifdef AXIS_UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [7:0]  maxis_data_o;
  logic [1:0]  maxis_tuser_o;
  logic        maxis_tvalid_o;
  logic        maxis_tready_i = 1'b1;
  logic        overrun_o;
  logic [31:0] delitel = 32'd16;
  logic        stop_bit_num = 1'b0;
  logic [2:0]  parity_bit_mode = 3'd0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int ovr_cnt = 0;
  int tv_hi = 0;
  logic tvalid_prev = 1'b0;
  logic [7:0] bd[$];
  logic [1:0] bu[$];

  axis_uart_rx dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx        (uart_rx),
    .maxis_data_o   (maxis_data_o),
    .maxis_tuser_o  (maxis_tuser_o),
    .maxis_tvalid_o (maxis_tvalid_o),
    .maxis_tready_i (maxis_tready_i),
    .overrun_o      (overrun_o),
    .delitel        (delitel),
    .stop_bit_num   (stop_bit_num),
    .parity_bit_mode(parity_bit_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record accepted beats, tvalid rises and overrun pulses.
  always @(negedge clk) begin
    if (maxis_tvalid_o && !tvalid_prev) rise_cyc = cyc;
    tvalid_prev = maxis_tvalid_o;
    if (maxis_tvalid_o) tv_hi++;
    if (overrun_o) ovr_cnt++;
    if (maxis_tvalid_o && maxis_tready_i && !rst) begin
      bd.push_back(maxis_data_o);
      bu.push_back(maxis_tuser_o);
      $display("beat %0d: data=%02h tuser=%0b cyc=%0d", bd.size(), maxis_data_o, maxis_tuser_o, cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v, input int p);
    @(posedge clk);
    #1 uart_rx = v;
    repeat (p - 1) @(posedge clk);
  endtask

  // Full frame; optionally scrambles the config registers after the start bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                            input logic two, input int p, input bit scramble);
    logic [31:0] sd;
    logic        ss;
    logic [2:0]  sm;
    @(posedge clk);
    #1 uart_rx = 1'b0;
    start_cyc = cyc;
    repeat (p - 1) @(posedge clk);
    sd = delitel; ss = stop_bit_num; sm = parity_bit_mode;
    if (scramble) begin
      delitel = 32'd9; stop_bit_num = ~ss; parity_bit_mode = 3'd1;
    end
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    send_bit(par, p);
    send_bit(s1, p);
    if (two) send_bit(1'b1, p);
    delitel = sd; stop_bit_num = ss; parity_bit_mode = sm;
  endtask

  function automatic int lat(input int p, input bit two);
    return p / 2 + 3 + 10 * p + (two ? p : 0) + MAJ;
  endfunction

  int n0, o0, t0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 32'(maxis_tvalid_o), 32'd0);
    chk("rst_data", 32'(maxis_data_o), 32'd0);
    chk("rst_tuser", 32'(maxis_tuser_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);

    // 0xA5, mode 3 (even), parity 0, one stop, config scrambled mid-frame
    delitel = 32'd16; stop_bit_num = 1'b0; parity_bit_mode = 3'd3;
    n0 = bd.size(); t0 = tv_hi;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 16, 1'b1);
    repeat (24) @(posedge clk);
    chk("a5_count", 32'(bd.size()), 32'(n0 + 1));
    chk("a5_data", 32'(bd[bd.size()-1]), 32'hA5);
    chk("a5_tuser", 32'(bu[bu.size()-1]), 32'd0);
    chk("a5_latency", 32'(rise_cyc - start_cyc), 32'(lat(16, 1'b0)));
    chk("a5_tvalid_width", 32'(tv_hi - t0), 32'd1);

    // 0x3C, mode 2 (odd, needs 1), parity 0 sent, two stops -> parity error
    stop_bit_num = 1'b1; parity_bit_mode = 3'd2;
    n0 = bd.size();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 16, 1'b0);
    repeat (24) @(posedge clk);
    chk("3c_count", 32'(bd.size()), 32'(n0 + 1));
    chk("3c_data", 32'(bd[bd.size()-1]), 32'h3C);
    chk("3c_tuser", 32'(bu[bu.size()-1]), 32'd1);
    chk("3c_latency", 32'(rise_cyc - start_cyc), 32'(lat(16, 1'b1)));

    // 0x55 with STOP1 = 0, line then held low (break) -> one flagged beat only
    stop_bit_num = 1'b0; parity_bit_mode = 3'd0;
    n0 = bd.size();
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 16, 1'b0);
    repeat (64) @(posedge clk);
    chk("55_count", 32'(bd.size()), 32'(n0 + 1));
    chk("55_data", 32'(bd[bd.size()-1]), 32'h55);
    chk("55_tuser", 32'(bu[bu.size()-1]), 32'd2);
    #1 uart_rx = 1'b1;
    repeat (32) @(posedge clk);
    chk("break_no_restart", 32'(bd.size()), 32'(n0 + 1));

    // 4-cycle glitch: false start, nothing delivered
    n0 = bd.size();
    #1 uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (48) @(posedge clk);
    chk("glitch_count", 32'(bd.size()), 32'(n0));

    // Receiver back in IDLE: mode 1 frame 0x80 with parity 1
    parity_bit_mode = 3'd1;
    n0 = bd.size();
    send_frame(8'h80, 1'b1, 1'b1, 1'b0, 16, 1'b0);
    repeat (24) @(posedge clk);
    chk("80_count", 32'(bd.size()), 32'(n0 + 1));
    chk("80_data", 32'(bd[bd.size()-1]), 32'h80);
    chk("80_tuser", 32'(bu[bu.size()-1]), 32'd0);

    // delitel = 2 clamps to P = 4
    delitel = 32'd2; parity_bit_mode = 3'd3;
    n0 = bd.size();
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 4, 1'b0);
    repeat (16) @(posedge clk);
    chk("c3_count", 32'(bd.size()), 32'(n0 + 1));
    chk("c3_data", 32'(bd[bd.size()-1]), 32'hC3);
    chk("c3_tuser", 32'(bu[bu.size()-1]), 32'd0);
    chk("c3_latency", 32'(rise_cyc - start_cyc), 32'(lat(4, 1'b0)));

    // Overrun: tready low, 0x11 then 0x22 back to back
    delitel = 32'd16; parity_bit_mode = 3'd0;
    #1 maxis_tready_i = 1'b0;
    n0 = bd.size(); o0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1, 1'b0, 16, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 16, 1'b0);
    repeat (32) @(posedge clk);
    @(negedge clk);
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_tvalid", 32'(maxis_tvalid_o), 32'd1);
    chk("ovr_held_data", 32'(maxis_data_o), 32'h11);
    chk("ovr_held_tuser", 32'(maxis_tuser_o), 32'd0);
    @(posedge clk);
    #1 maxis_tready_i = 1'b1;
    repeat (48) @(posedge clk);
    chk("ovr_count", 32'(bd.size()), 32'(n0 + 1));
    chk("ovr_accepted", 32'(bd[bd.size()-1]), 32'h11);
    @(negedge clk);
    chk("ovr_drained", 32'(maxis_tvalid_o), 32'd0);

    // Reset mid data bit 4 with a pending byte, then a clean 0x0F
    #1 maxis_tready_i = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 16, 1'b0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("pend_data", 32'(maxis_data_o), 32'h5A);
    n0 = bd.size();
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 16);
    @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_tvalid", 32'(maxis_tvalid_o), 32'd0);
    chk("mid_rst_data", 32'(maxis_data_o), 32'd0);
    #1 rst = 1'b0;
    maxis_tready_i = 1'b1;
    repeat (40) @(posedge clk);
    chk("post_rst_nobeat", 32'(bd.size()), 32'(n0));
    send_frame(8'h0F, 1'b0, 1'b1, 1'b0, 16, 1'b0);
    repeat (24) @(posedge clk);
    chk("0f_count", 32'(bd.size()), 32'(n0 + 1));
    chk("0f_data", 32'(bd[bd.size()-1]), 32'h0F);
    chk("0f_tuser", 32'(bu[bu.size()-1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
